// File: rtl/cpu_mem_responder.sv
// CPU data-memory responder with buffered video writes. dmem_out is 1 cycle after the address; video writes go out the cycle after their push.
// The video port may stall under valid/ready; CPU video writes that arrive while the FIFO is full and not popping are dropped, and overflow is latched.
module sync_fifo #(
  parameter int W     = 24,
  parameter int DEPTH = 4,
  parameter int CW    = 3
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          in_vld,
  input  logic [W-1:0]  in_dat,
  output logic          in_rdy,
  output logic          out_vld,
  output logic [W-1:0]  out_dat,
  input  logic          out_rdy,
  output logic [CW-1:0] count
);
  localparam int AW = CW - 1;
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

  logic [W-1:0]  store [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          push;
  logic          pop;

  assign out_vld = (count != '0);
  assign out_dat = store[rd_ptr];
  assign pop     = out_vld && out_rdy;
  // A full FIFO still accepts a write when the head leaves in the same cycle.
  assign in_rdy  = (count != FULL_CNT) || pop;
  assign push    = in_vld && in_rdy;

  always_ff @(posedge clock) begin
    if (push) begin
      store[wr_ptr] <= in_dat;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end
endmodule

module cpu_mem_responder #(
  parameter int DMEM_AW    = 8,
  parameter int FIFO_DEPTH = 4,
  parameter int CW         = 3
) (
  input  logic          clock,
  input  logic          reset,
  input  logic [15:0]   mem_addr,
  input  logic          dmem_we,
  input  logic          vmem_we,
  input  logic [7:0]    wdata,
  output logic [7:0]    dmem_out,
  output logic [15:0]   vmem_addr,
  output logic [7:0]    vmem_data,
  output logic          vmem_wr,
  input  logic          vmem_ready,
  output logic [CW-1:0] fifo_count,
  output logic          fifo_full,
  output logic          overflow
);
  localparam logic [CW-1:0] FULL_CNT = CW'(FIFO_DEPTH);

  logic [7:0]         dmem [2**DMEM_AW];
  logic [DMEM_AW-1:0] idx;
  logic               push_rdy;
  logic [23:0]        head_dat;

  assign idx = mem_addr[DMEM_AW-1:0];

  always_ff @(posedge clock) begin
    if (dmem_we) begin
      dmem[idx] <= wdata;
    end
  end

  // Write-first: a same-cycle write to the read index returns the new byte.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      dmem_out <= 8'hff;
    end else begin
      dmem_out <= dmem_we ? wdata : dmem[idx];
    end
  end

  sync_fifo #(
    .W     (24),
    .DEPTH (FIFO_DEPTH),
    .CW    (CW)
  ) u_vfifo (
    .clock   (clock),
    .reset   (reset),
    .in_vld  (vmem_we),
    .in_dat  ({mem_addr, wdata}),
    .in_rdy  (push_rdy),
    .out_vld (vmem_wr),
    .out_dat (head_dat),
    .out_rdy (vmem_ready),
    .count   (fifo_count)
  );

  assign vmem_addr = head_dat[23:8];
  assign vmem_data = head_dat[7:0];
  assign fifo_full = (fifo_count == FULL_CNT);

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      overflow <= 1'b0;
    end else if (vmem_we && !push_rdy) begin
      overflow <= 1'b1;
    end
  end
endmodule

// File: tb/tb_cpu_mem_responder.sv
// Randomized and directed bench for cpu_mem_responder against a queue/array reference model.
module tb_cpu_mem_responder;
  localparam int DEPTH = 4;

  logic        clock;
  logic        reset;
  logic [15:0] mem_addr;
  logic        dmem_we;
  logic        vmem_we;
  logic [7:0]  wdata;
  logic [7:0]  dmem_out;
  logic [15:0] vmem_addr;
  logic [7:0]  vmem_data;
  logic        vmem_wr;
  logic        vmem_ready;
  logic [2:0]  fifo_count;
  logic        fifo_full;
  logic        overflow;

  cpu_mem_responder #(.DMEM_AW(8), .FIFO_DEPTH(DEPTH), .CW(3)) dut (
    .clock      (clock),
    .reset      (reset),
    .mem_addr   (mem_addr),
    .dmem_we    (dmem_we),
    .vmem_we    (vmem_we),
    .wdata      (wdata),
    .dmem_out   (dmem_out),
    .vmem_addr  (vmem_addr),
    .vmem_data  (vmem_data),
    .vmem_wr    (vmem_wr),
    .vmem_ready (vmem_ready),
    .fifo_count (fifo_count),
    .fifo_full  (fifo_full),
    .overflow   (overflow)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int vectors = 0;
  int miscompares = 0;

  // reference model state
  logic [23:0] q[$];
  logic [7:0]  mem_m [256];
  bit          mk [256];
  logic [7:0]  exp_dout;
  bit          dk;
  bit          ovf;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic check_outputs();
    if (dk) chk("dmem_out", 32'(dmem_out), 32'(exp_dout));
    chk("vmem_wr", 32'(vmem_wr), 32'(q.size() != 0));
    chk("fifo_count", 32'(fifo_count), 32'(q.size()));
    chk("fifo_full", 32'(fifo_full), 32'(q.size() == DEPTH));
    chk("overflow", 32'(overflow), 32'(ovf));
    if (q.size() != 0) begin
      chk("vmem_addr", 32'(vmem_addr), 32'(q[0][23:8]));
      chk("vmem_data", 32'(vmem_data), 32'(q[0][7:0]));
    end
  endtask

  task automatic step(input logic [15:0] a, input logic dwe, input logic vwe,
                      input logic [7:0] wd, input logic rdy);
    bit pop;
    bit push;
    int i;
    mem_addr = a; dmem_we = dwe; vmem_we = vwe; wdata = wd; vmem_ready = rdy;
    i = int'(a[7:0]);
    pop  = (q.size() != 0) && rdy;
    push = vwe && ((q.size() < DEPTH) || pop);
    if (pop) void'(q.pop_front());
    if (push) q.push_back({a, wd});
    if (vwe && !push) ovf = 1'b1;
    if (dwe) begin
      exp_dout = wd; dk = 1'b1; mem_m[i] = wd; mk[i] = 1'b1;
    end else begin
      exp_dout = mem_m[i]; dk = mk[i];
    end
    @(posedge clock); #1;
    check_outputs();
  endtask

  task automatic model_reset();
    q.delete();
    ovf = 1'b0;
    exp_dout = 8'hff;
    dk = 1'b1;
  endtask

  initial begin
    logic [7:0] d3 [3];
    d3[0] = 8'h11; d3[1] = 8'h22; d3[2] = 8'h33;
    for (int i = 0; i < 256; i++) mk[i] = 1'b0;
    reset = 1'b0; mem_addr = '0; dmem_we = 0; vmem_we = 0; wdata = '0; vmem_ready = 0;
    model_reset();
    repeat (3) @(posedge clock);
    #1 reset = 1'b1;
    chk("rst_dout", 32'(dmem_out), 32'h ff);
    chk("rst_vmem_wr", 32'(vmem_wr), 32'h0);
    chk("rst_count", 32'(fifo_count), 32'h0);
    chk("rst_ovf", 32'(overflow), 32'h0);

    // data memory read, aliasing, write-first
    step(16'h0010, 1, 0, 8'h5a, 0);
    step(16'h0010, 0, 0, 8'h00, 0);
    chk("rd_0010", 32'(dmem_out), 32'h5a);
    step(16'h0110, 0, 0, 8'h00, 0);
    chk("rd_alias_0110", 32'(dmem_out), 32'h5a);
    step(16'h0003, 1, 0, 8'hc3, 0);
    chk("write_first", 32'(dmem_out), 32'hc3);

    // ordering
    for (int i = 0; i < 3; i++) step(16'h8000 + 16'(i), 0, 1, d3[i], 0);
    chk("ord_count", 32'(fifo_count), 32'd3);
    chk("ord_head_addr", 32'(vmem_addr), 32'h8000);
    for (int i = 0; i < 3; i++) begin
      chk("ord_data", 32'(vmem_data), 32'(d3[i]));
      step(16'h0, 0, 0, 8'h0, 1);
    end
    chk("ord_empty", 32'(vmem_wr), 32'h0);

    // simultaneous push/pop while full
    for (int i = 0; i < 4; i++) step(16'h8100 + 16'(i), 0, 1, 8'h40 + 8'(i), 0);
    step(16'h9000, 0, 1, 8'haa, 1);
    chk("pp_count", 32'(fifo_count), 32'd4);
    chk("pp_ovf", 32'(overflow), 32'h0);
    for (int i = 0; i < 4; i++) begin
      if (i == 3) chk("pp_last", 32'(vmem_data), 32'haa);
      step(16'h0, 0, 0, 8'h0, 1);
    end

    // overflow
    for (int i = 0; i < 5; i++) begin
      step(16'h8200 + 16'(i), 0, 1, 8'h60 + 8'(i), 0);
      if (i == 3) chk("ovf_full", 32'(fifo_full), 32'h1);
    end
    chk("ovf_set", 32'(overflow), 32'h1);
    for (int i = 0; i < 4; i++) begin
      chk("ovf_drain", 32'(vmem_data), 32'h60 + 32'(i));
      step(16'h0, 0, 0, 8'h0, 1);
    end
    chk("ovf_drained", 32'(vmem_wr), 32'h0);
    step(16'h0, 0, 0, 8'h0, 1);
    chk("ovf_sticky", 32'(overflow), 32'h1);

    // async reset mid-drain
    step(16'h8300, 0, 1, 8'h71, 0);
    step(16'h8301, 0, 1, 8'h72, 0);
    chk("ar_count2", 32'(fifo_count), 32'd2);
    #4 reset = 1'b0;
    #1;
    model_reset();
    chk("ar_vmem_wr", 32'(vmem_wr), 32'h0);
    chk("ar_count", 32'(fifo_count), 32'h0);
    chk("ar_ovf", 32'(overflow), 32'h0);
    #2 reset = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step(16'h0, 0, 0, 8'h0, 1);
      chk("ar_no_wr", 32'(vmem_wr), 32'h0);
    end

    // randomized traffic
    for (int n = 0; n < 3000; n++) begin
      logic [15:0] a;
      a = 16'($urandom);
      if ($urandom_range(0, 3) == 0) a[15:8] = 8'h00;
      step(a, 1'($urandom_range(0, 2) == 0), 1'($urandom_range(0, 1)),
           8'($urandom), 1'($urandom_range(0, 9) < 6));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
